// File: rtl/ping_pong_pkg.sv
// Shared encodings for the two-player, two-ball ping-pong protocol.
// The players and the umpire both use these.
package ping_pong_pkg;

    typedef enum logic {
        HIT  = 1'b0,
        IDLE = 1'b1
    } action_t;

    typedef enum logic {
        PLAYER_READY   = 1'b0,
        PLAYER_STALLED = 1'b1
    } player_status_t;

    typedef enum logic [1:0] {
        TO_A        = 2'd0,
        TO_B        = 2'd1,
        OUT_OF_PLAY = 2'd2
    } ball_status_t;

endpackage

// File: rtl/ping_pong_umpire_if.sv
// Shared action bus: the players drive it and the umpire only observes it.
interface ping_pong_umpire_if;
    import ping_pong_pkg::*;

    action_t action_a;
    action_t action_b;

    modport master (output action_a, output action_b);
    modport slave  (input  action_a, input  action_b);
endinterface

// File: rtl/ping_pong_ball_tracker.sv
// Tracks one ball. The state is registered; the next state is also exported
// so the umpire can detect when both balls go out on the same edge.
//
//  state        | meaning
//  TO_A         | ball travelling towards player A
//  TO_B         | ball travelling towards player B
//  OUT_OF_PLAY  | ball lost (absorbing)
module ping_pong_ball_tracker
    import ping_pong_pkg::*;
#(
    parameter ball_status_t INIT = TO_A
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         hit_a,
    input  logic         hit_b,
    output ball_status_t state,
    output ball_status_t state_nxt
);

    always_comb begin
        state_nxt = OUT_OF_PLAY;
        case (state)
            TO_A:    state_nxt = hit_a ? TO_B : (hit_b ? OUT_OF_PLAY : TO_A);
            TO_B:    state_nxt = hit_b ? TO_A : (hit_a ? OUT_OF_PLAY : TO_B);
            default: state_nxt = OUT_OF_PLAY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= INIT;
        else
            state <= state_nxt;
    end

endmodule

// File: rtl/ping_pong_umpire.sv
// Passive umpire for the ping-pong action bus: follows both balls, counts
// legal hits and raises sticky violation flags.
module ping_pong_umpire
    import ping_pong_pkg::*;
#(
    parameter int CNT_W    = 8,
    parameter int MAX_WAIT = 15,
    parameter int WAIT_W   = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    ping_pong_umpire_if.slave  bus,
    output ball_status_t       ball1_state,
    output ball_status_t       ball2_state,
    output logic [1:0]         balls_in_play,
    output logic [CNT_W-1:0]   hit_count,
    output logic               err_phantom_a,
    output logic               err_phantom_b,
    output logic               err_stall,
    output logic               err_both_out,
    output logic               err_any
);

    localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(MAX_WAIT);

    logic               hit_a, hit_b;
    logic               ball_to_a, ball_to_b;
    logic               legal_a, legal_b;
    ball_status_t       ball1_nxt, ball2_nxt;
    logic [WAIT_W-1:0]  wait_a, wait_b, wait_a_nxt, wait_b_nxt;
    logic [CNT_W:0]     cnt_sum;
    logic [CNT_W-1:0]   hit_count_nxt;
    logic [1:0]         balls_in_play_nxt;

    assign hit_a = (bus.action_a == HIT);
    assign hit_b = (bus.action_b == HIT);

    ping_pong_ball_tracker #(.INIT(TO_A)) u_ball1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .hit_a     (hit_a),
        .hit_b     (hit_b),
        .state     (ball1_state),
        .state_nxt (ball1_nxt)
    );

    ping_pong_ball_tracker #(.INIT(TO_B)) u_ball2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .hit_a     (hit_a),
        .hit_b     (hit_b),
        .state     (ball2_state),
        .state_nxt (ball2_nxt)
    );

    assign ball_to_a = (ball1_state == TO_A) || (ball2_state == TO_A);
    assign ball_to_b = (ball1_state == TO_B) || (ball2_state == TO_B);
    assign legal_a   = hit_a && ball_to_a;
    assign legal_b   = hit_b && ball_to_b;

    // At most +2 per cycle from a value <= max, so the carry bit alone flags overflow.
    always_comb begin
        cnt_sum       = {1'b0, hit_count} + (CNT_W+1)'(legal_a) + (CNT_W+1)'(legal_b);
        hit_count_nxt = cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
    end

    always_comb begin
        wait_a_nxt = wait_a;
        if (hit_a || !ball_to_a)
            wait_a_nxt = '0;
        else if (wait_a != WAIT_LIM)
            wait_a_nxt = wait_a + WAIT_W'(1);
    end

    always_comb begin
        wait_b_nxt = wait_b;
        if (hit_b || !ball_to_b)
            wait_b_nxt = '0;
        else if (wait_b != WAIT_LIM)
            wait_b_nxt = wait_b + WAIT_W'(1);
    end

    assign balls_in_play_nxt = 2'(ball1_nxt != OUT_OF_PLAY) + 2'(ball2_nxt != OUT_OF_PLAY);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            balls_in_play <= 2'd2;
            hit_count     <= '0;
            wait_a        <= '0;
            wait_b        <= '0;
            err_phantom_a <= 1'b0;
            err_phantom_b <= 1'b0;
            err_stall     <= 1'b0;
            err_both_out  <= 1'b0;
        end else begin
            balls_in_play <= balls_in_play_nxt;
            hit_count     <= hit_count_nxt;
            wait_a        <= wait_a_nxt;
            wait_b        <= wait_b_nxt;
            err_phantom_a <= err_phantom_a | (hit_a && !ball_to_a);
            err_phantom_b <= err_phantom_b | (hit_b && !ball_to_b);
            err_stall     <= err_stall | (wait_a_nxt == WAIT_LIM) | (wait_b_nxt == WAIT_LIM);
            err_both_out  <= err_both_out | ((ball1_nxt == OUT_OF_PLAY) && (ball2_nxt == OUT_OF_PLAY));
        end
    end

    assign err_any = err_phantom_a | err_phantom_b | err_stall | err_both_out;

endmodule

// File: tb/tb_ping_pong_umpire.sv
// Directed bench for ping_pong_umpire with hand-computed expectations.
module tb_ping_pong_umpire;
    import ping_pong_pkg::*;

    logic         clk;
    logic         rst_n;
    ball_status_t ball1_state, ball2_state;
    logic [1:0]   balls_in_play;
    logic [7:0]   hit_count;
    logic         err_phantom_a, err_phantom_b, err_stall, err_both_out, err_any;

    int errors = 0;
    int checks = 0;

    ping_pong_umpire_if bus ();

    ping_pong_umpire #(.CNT_W(8), .MAX_WAIT(15), .WAIT_W(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .bus           (bus),
        .ball1_state   (ball1_state),
        .ball2_state   (ball2_state),
        .balls_in_play (balls_in_play),
        .hit_count     (hit_count),
        .err_phantom_a (err_phantom_a),
        .err_phantom_b (err_phantom_b),
        .err_stall     (err_stall),
        .err_both_out  (err_both_out),
        .err_any       (err_any)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.action_a = IDLE;
        bus.action_b = IDLE;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (ball1_state !== TO_A) begin errors++; $display("FAIL reset_ball1: got %0d expected %0d", ball1_state, TO_A); end
        checks++; if (ball2_state !== TO_B) begin errors++; $display("FAIL reset_ball2: got %0d expected %0d", ball2_state, TO_B); end
        checks++; if (balls_in_play !== 2'd2) begin errors++; $display("FAIL reset_bip: got %0d expected 2", balls_in_play); end
        checks++; if (hit_count !== 8'd0) begin errors++; $display("FAIL reset_hits: got %0d expected 0", hit_count); end
        checks++; if ({err_phantom_a, err_phantom_b, err_stall, err_both_out, err_any} !== 5'b0) begin
            errors++; $display("FAIL reset_errs: got %b expected 00000", {err_phantom_a, err_phantom_b, err_stall, err_both_out, err_any});
        end
    endtask

    task automatic test_rally_swap();
        ball_status_t exp1, exp2;
        do_reset();
        bus.action_a = HIT;
        bus.action_b = HIT;
        for (int k = 1; k <= 4; k++) begin
            tick();
            exp1 = (k % 2 == 1) ? TO_B : TO_A;
            exp2 = (k % 2 == 1) ? TO_A : TO_B;
            checks++; if (ball1_state !== exp1 || ball2_state !== exp2) begin
                errors++; $display("FAIL swap_cycle%0d: got %0d/%0d expected %0d/%0d", k, ball1_state, ball2_state, exp1, exp2);
            end
            checks++; if (hit_count !== 8'(2*k)) begin errors++; $display("FAIL swap_hits%0d: got %0d expected %0d", k, hit_count, 2*k); end
        end
        checks++; if (err_any !== 1'b0 || balls_in_play !== 2'd2) begin
            errors++; $display("FAIL swap_clean: got err_any=%b bip=%0d expected 0/2", err_any, balls_in_play);
        end
    endtask

    task automatic test_ball_loss();
        do_reset();
        bus.action_a = IDLE;
        bus.action_b = HIT;
        tick();
        checks++; if (ball1_state !== OUT_OF_PLAY) begin errors++; $display("FAIL loss_ball1: got %0d expected %0d", ball1_state, OUT_OF_PLAY); end
        checks++; if (ball2_state !== TO_A) begin errors++; $display("FAIL loss_ball2: got %0d expected %0d", ball2_state, TO_A); end
        checks++; if (balls_in_play !== 2'd1) begin errors++; $display("FAIL loss_bip: got %0d expected 1", balls_in_play); end
        checks++; if (hit_count !== 8'd1) begin errors++; $display("FAIL loss_hits: got %0d expected 1", hit_count); end
        checks++; if (err_any !== 1'b0) begin errors++; $display("FAIL loss_noerr: got %b expected 0", err_any); end
        tick();
        checks++; if (err_phantom_b !== 1'b1 || err_phantom_a !== 1'b0) begin
            errors++; $display("FAIL phantom_b: got a=%b b=%b expected a=0 b=1", err_phantom_a, err_phantom_b);
        end
        checks++; if (ball2_state !== OUT_OF_PLAY) begin errors++; $display("FAIL phantom_ball2: got %0d expected %0d", ball2_state, OUT_OF_PLAY); end
        checks++; if (err_both_out !== 1'b1 || balls_in_play !== 2'd0) begin
            errors++; $display("FAIL both_out: got flag=%b bip=%0d expected 1/0", err_both_out, balls_in_play);
        end
        checks++; if (hit_count !== 8'd1) begin errors++; $display("FAIL phantom_hits: got %0d expected 1", hit_count); end
        checks++; if (err_any !== 1'b1) begin errors++; $display("FAIL phantom_any: got %b expected 1", err_any); end
    endtask

    task automatic test_stall();
        do_reset();
        bus.action_a = IDLE;
        bus.action_b = IDLE;
        repeat (14) tick();
        checks++; if (err_stall !== 1'b0) begin errors++; $display("FAIL stall_14: got %b expected 0", err_stall); end
        tick();
        checks++; if (err_stall !== 1'b1 || err_any !== 1'b1) begin
            errors++; $display("FAIL stall_15: got stall=%b any=%b expected 1/1", err_stall, err_any);
        end
        repeat (3) tick();
        checks++; if (err_stall !== 1'b1 || ball1_state !== TO_A || ball2_state !== TO_B) begin
            errors++; $display("FAIL stall_sticky: got stall=%b balls=%0d/%0d expected 1 0/1", err_stall, ball1_state, ball2_state);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        bus.action_a = HIT;
        bus.action_b = HIT;
        repeat (127) tick();
        checks++; if (hit_count !== 8'd254) begin errors++; $display("FAIL sat_254: got %0d expected 254", hit_count); end
        tick();
        checks++; if (hit_count !== 8'd255) begin errors++; $display("FAIL sat_255: got %0d expected 255", hit_count); end
        repeat (3) tick();
        checks++; if (hit_count !== 8'd255) begin errors++; $display("FAIL sat_hold: got %0d expected 255", hit_count); end
        checks++; if (err_any !== 1'b0) begin errors++; $display("FAIL sat_noerr: got %b expected 0", err_any); end
    endtask

    task automatic test_async_reset();
        do_reset();
        bus.action_a = HIT;
        bus.action_b = HIT;
        tick();
        bus.action_a = IDLE;
        bus.action_b = HIT;
        tick();
        tick();
        checks++; if (err_any !== 1'b1 || hit_count === 8'd0) begin
            errors++; $display("FAIL pre_reset: got any=%b hits=%0d expected 1 and nonzero", err_any, hit_count);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (ball1_state !== TO_A || ball2_state !== TO_B || balls_in_play !== 2'd2) begin
            errors++; $display("FAIL async_balls: got %0d/%0d bip=%0d expected 0/1 bip=2", ball1_state, ball2_state, balls_in_play);
        end
        checks++; if (hit_count !== 8'd0 || err_any !== 1'b0) begin
            errors++; $display("FAIL async_clear: got hits=%0d any=%b expected 0/0", hit_count, err_any);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        bus.action_a = IDLE;
        bus.action_b = IDLE;
        test_reset();
        test_rally_swap();
        test_ball_loss();
        test_stall();
        test_saturation();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
